nn_io_scheduler: RTL and testbench
==================================

// Module: nn_io_scheduler
// PURPOSE
//  Front-end sequencer directly upstream of the nn core. Buffers input pairs
//  from a valid/ready source, issues the weight-load enable after reset, then
//  feeds one pair at a time to the nn core with a single-cycle enable pulse.
//  Captures final_output/ovf/zero after the fixed core latency and presents
//  them on a valid/ready result port. Exactly one operation in flight.
// PARAMETERS
//  DATA_W      32  width of inputs/outputs (signed, two's complement)
//  FIFO_DEPTH  4   input pair FIFO entries (power of 2, >=2)
//  LOAD_WAIT   15  cycles waited after the load enable before loaded=1
//  NN_LATENCY  7   cycles from the enable-high cycle to the result-sample cycle
// PORTS
//  clk              in   1       clock, rising edge
//  resetn           in   1       asynchronous active-low reset
//  in_valid         in   1       input pair valid
//  in_ready         out  1       FIFO not full
//  in_data1         in   DATA_W  input pair element 1 (signed)
//  in_data2         in   DATA_W  input pair element 2 (signed)
//  out_valid        out  1       result valid
//  out_ready        in   1       result consumer ready
//  out_data         out  DATA_W  captured nn final_output
//  out_ovf          out  1       captured nn total_ovf
//  out_zero         out  1       captured nn total_zero
//  nn_enable        out  1       enable to nn core (1-cycle pulses only)
//  nn_input_1       out  DATA_W  to nn input_1 (registered)
//  nn_input_2       out  DATA_W  to nn input_2 (registered)
//  nn_final_output  in   DATA_W  from nn final_output
//  nn_total_ovf     in   1       from nn total_ovf
//  nn_total_zero    in   1       from nn total_zero
//  loaded           out  1       weight load complete
//  busy             out  1       state!=IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (async, resetn=0): state=LOAD_EN, FIFO empty, nn_enable=0,
//   nn_input_1/2=0, out_valid=0, out_data=0, out_ovf=0, out_zero=0, loaded=0.
//   in_ready=1 (combinational !full), busy=1. Reset mid-operation discards
//   everything, including FIFO contents and pending results; load restarts.
//  FSM:
//   LOAD_EN  : nn_enable=1 one cycle, nn_inputs=0 -> LOAD_WT.
//   LOAD_WT  : count LOAD_WAIT cycles -> loaded=1 (sticky until reset), IDLE.
//   IDLE     : if FIFO non-empty: pop head into nn_input_1/2 -> ISSUE.
//   ISSUE    : nn_enable=1 one cycle; nn_inputs held -> WAIT.
//   WAIT     : sample on the NN_LATENCY-th cycle after the ISSUE cycle
//              (ISSUE cycle is 0): out_data/ovf/zero <= nn_*, out_valid=1 -> HOLD.
//   HOLD     : out_* stable while out_valid & !out_ready; on out_ready:
//              out_valid=0 -> IDLE (pop can occur next cycle).
//  nn_input_1/2 are held from pop until the next pop; they never change in
//   ISSUE/WAIT.
//  nn_enable is never high two consecutive cycles and is never asserted
//   outside LOAD_EN/ISSUE.
//  FIFO: push when in_valid & in_ready, allowed in any state, including load.
//   in_ready = count<FIFO_DEPTH only. No push when full, even with a same-cycle
//   pop. Simultaneous push+pop when not full: count unchanged.
//   Pointers wrap modulo FIFO_DEPTH. Strict FIFO ordering.
//  No pop before loaded=1. Data is passed bit-exact; no arithmetic on data.
//  out_data/flags keep their last value after the handshake until the next
//   capture.
// TESTING
//  T1 release reset -> nn_enable=1 exactly cycle 0 with nn_inputs=0;
//     loaded=1 after 1+15 cycles; no further enable before that point.
//  T2 after load, push (100,-200), out_ready=1 -> nn_input_1=100,
//     nn_input_2=-200, one enable pulse; out_valid 7 cycles later;
//     out_data equals the stub nn value.
//  T3 push 6 pairs during load with in_valid held -> exactly 4 accepted,
//     in_ready=0 after the 4th; the 4 results appear in push order.
//  T4 out_ready=0 for 20 cycles in HOLD -> out_data/ovf/zero stable, no
//     nn_enable; out_ready=1 -> next ISSUE within 2 cycles.
//  T5 stub drives total_ovf=1, total_zero=0, output 32'h7FFFFFFF ->
//     out_ovf=1, out_zero=0, out_data=32'h7FFFFFFF.
//  T6 resetn=0 mid-WAIT with 2 pairs queued -> all outputs return to reset
//     values asynchronously; after release, load resumes, queued pairs are
//     gone, no stale out_valid.

Source files
------------

// File: rtl/nn_io_scheduler.sv
// Front-end sequencer for the nn core: buffers input pairs, performs the
// post-reset weight-load pulse, then runs exactly one core operation at a time.
module nn_io_scheduler #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LOAD_WAIT  = 15,
  parameter int NN_LATENCY = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              out_zero,
  output logic              nn_enable,
  output logic [DATA_W-1:0] nn_input_1,
  output logic [DATA_W-1:0] nn_input_2,
  input  logic [DATA_W-1:0] nn_final_output,
  input  logic              nn_total_ovf,
  input  logic              nn_total_zero,
  output logic              loaded,
  output logic              busy
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (LOAD_WAIT > NN_LATENCY) ? LOAD_WAIT : NN_LATENCY;
  localparam int CW    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_LOAD_EN,
    S_LOAD_WT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  // Input pair FIFO: element 1 in the upper half, element 2 in the lower half.
  logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_next;

  logic                r_nn_enable;
  logic                w_nn_enable_next;
  logic [DATA_W-1:0]   r_nn_in1;
  logic [DATA_W-1:0]   r_nn_in2;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_ovf;
  logic                r_out_zero;
  logic                r_loaded;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_capture;
  logic                w_release;
  logic                w_load_done;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign w_push  = in_valid & ~w_full;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_nn_enable_next = 1'b0;
    w_pop            = 1'b0;
    w_capture        = 1'b0;
    w_release        = 1'b0;
    w_load_done      = 1'b0;
    case (r_state)
      S_LOAD_EN: begin
        w_nn_enable_next = 1'b1;
        w_cnt_next       = '0;
        w_state_next     = S_LOAD_WT;
      end
      S_LOAD_WT: begin
        if (r_cnt == CW'(LOAD_WAIT - 1)) begin
          w_load_done  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_IDLE: begin
        if (!w_empty) begin
          w_pop            = 1'b1;
          w_nn_enable_next = 1'b1;
          w_state_next     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The cycle after ISSUE is cycle 1 of the core latency window.
        w_cnt_next   = CW'(1);
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == CW'(NN_LATENCY - 1)) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_LOAD_EN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_LOAD_EN;
      r_cnt       <= '0;
      r_nn_enable <= 1'b0;
      r_nn_in1    <= '0;
      r_nn_in2    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_zero  <= 1'b0;
      r_loaded    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_nn_enable <= w_nn_enable_next;
      if (w_pop) begin
        r_nn_in1 <= r_mem[r_rd_ptr][2*DATA_W-1:DATA_W];
        r_nn_in2 <= r_mem[r_rd_ptr][DATA_W-1:0];
      end
      if (w_capture) begin
        r_out_data  <= nn_final_output;
        r_out_ovf   <= nn_total_ovf;
        r_out_zero  <= nn_total_zero;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
      if (w_load_done) begin
        r_loaded <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_data1, in_data2};
    end
  end

  assign in_ready   = ~w_full;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ovf    = r_out_ovf;
  assign out_zero   = r_out_zero;
  assign nn_enable  = r_nn_enable;
  assign nn_input_1 = r_nn_in1;
  assign nn_input_2 = r_nn_in2;
  assign loaded     = r_loaded;
  assign busy       = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_nn_io_scheduler.sv
// Self-checking bench for nn_io_scheduler: stub nn core plus a timestamp-based
// reference model of the scheduler, checked every cycle.
module tb_nn_io_scheduler;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LW     = 15;
  localparam int LAT    = 7;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;
  logic              out_zero;
  logic              nn_enable;
  logic [DATA_W-1:0] nn_input_1;
  logic [DATA_W-1:0] nn_input_2;
  logic [DATA_W-1:0] nn_final_output;
  logic              nn_total_ovf;
  logic              nn_total_zero;
  logic              loaded;
  logic              busy;

  always #5 clk = ~clk;

  nn_io_scheduler #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .LOAD_WAIT(LW), .NN_LATENCY(LAT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_zero(out_zero),
    .nn_enable(nn_enable), .nn_input_1(nn_input_1), .nn_input_2(nn_input_2),
    .nn_final_output(nn_final_output), .nn_total_ovf(nn_total_ovf),
    .nn_total_zero(nn_total_zero),
    .loaded(loaded), .busy(busy)
  );

  // Stub core: latches its inputs on an enable, produces junk until its result
  // is ready just in time for a capture LAT cycles after the enable cycle.
  int          stub_cnt;
  logic [31:0] stub_a;
  logic [31:0] stub_b;
  bit          force_mode;

  function automatic logic [31:0] core_sum(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  function automatic logic core_ovf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stub_cnt <= 0;
      stub_a   <= '0;
      stub_b   <= '0;
    end else if (nn_enable) begin
      stub_cnt <= 1;
      stub_a   <= nn_input_1;
      stub_b   <= nn_input_2;
    end else if (stub_cnt != 0 && stub_cnt < 100) begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign nn_final_output = (stub_cnt < LAT - 1) ? 32'hBAD00BAD :
                           force_mode ? 32'h7FFFFFFF : core_sum(stub_a, stub_b);
  assign nn_total_ovf    = (stub_cnt < LAT - 1) ? 1'b1 :
                           force_mode ? 1'b1 : core_ovf(stub_a, stub_b);
  assign nn_total_zero   = (stub_cnt < LAT - 1) ? 1'b1 :
                           force_mode ? 1'b0 : (core_sum(stub_a, stub_b) == 32'd0);

  // Reference model: k counts clock edges since reset release.
  logic [63:0] m_q[$];
  int          m_k;
  bit          m_inflight;
  int          m_pop_edge;
  logic [31:0] m_in1;
  logic [31:0] m_in2;
  logic [31:0] m_out;
  logic        m_ovf;
  logic        m_zero;
  bit          m_en;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, m_k, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_k        = 0;
    m_inflight = 0;
    m_pop_edge = 0;
    m_in1      = '0;
    m_in2      = '0;
    m_out      = '0;
    m_ovf      = 1'b0;
    m_zero     = 1'b0;
    m_en       = 0;
  endtask

  task automatic model_edge();
    int size0;
    bit push, pop, cap, hs;
    size0 = m_q.size();
    push  = in_valid && (size0 < DEPTH);
    pop   = (m_k > LW) && !m_inflight && (size0 > 0);
    cap   = m_inflight && (m_k == m_pop_edge + LAT);
    hs    = m_inflight && (m_k >= m_pop_edge + LAT + 1) && out_ready;
    if (cap) begin
      m_out  = force_mode ? 32'h7FFFFFFF : core_sum(m_in1, m_in2);
      m_ovf  = force_mode ? 1'b1 : core_ovf(m_in1, m_in2);
      m_zero = force_mode ? 1'b0 : (core_sum(m_in1, m_in2) == 32'd0);
    end
    if (hs) m_inflight = 0;
    if (pop) begin
      {m_in1, m_in2} = m_q.pop_front();
      m_inflight = 1;
      m_pop_edge = m_k;
    end
    if (push) m_q.push_back({in_data1, in_data2});
    m_en = (m_k == 0) || pop;
  endtask

  task automatic tick();
    bit exp_ov;
    @(posedge clk);
    model_edge();
    #1;
    exp_ov = m_inflight && (m_k >= m_pop_edge + LAT);
    chk("nn_enable",  64'(nn_enable),  64'(m_en));
    chk("nn_input_1", 64'(nn_input_1), 64'(m_in1));
    chk("nn_input_2", 64'(nn_input_2), 64'(m_in2));
    chk("out_valid",  64'(out_valid),  64'(exp_ov));
    chk("out_data",   64'(out_data),   64'(m_out));
    chk("out_ovf",    64'(out_ovf),    64'(m_ovf));
    chk("out_zero",   64'(out_zero),   64'(m_zero));
    chk("loaded",     64'(loaded),     64'(m_k >= LW));
    chk("in_ready",   64'(in_ready),   64'(m_q.size() < DEPTH));
    chk("busy",       64'(busy),       64'((m_k < LW) || m_inflight || (m_q.size() > 0)));
    m_k++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_nn_enable"}, 64'(nn_enable), 64'(0));
    chk({tag, "_nn_in1"},    64'(nn_input_1), 64'(0));
    chk({tag, "_nn_in2"},    64'(nn_input_2), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_data"},  64'(out_data),  64'(0));
    chk({tag, "_out_ovf"},   64'(out_ovf),   64'(0));
    chk({tag, "_out_zero"},  64'(out_zero),  64'(0));
    chk({tag, "_loaded"},    64'(loaded),    64'(0));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
    chk({tag, "_busy"},      64'(busy),      64'(1));
  endtask

  initial begin
    bit found;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_data1   = '0;
    in_data2   = '0;
    force_mode = 0;
    model_reset();

    // Reset state, then load sequence with 6 pairs offered (first is 100,-200).
    repeat (3) @(posedge clk);
    #1 chk_reset("rst0");
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data1 = (i == 0) ? 32'd100 : $urandom;
      in_data2 = (i == 0) ? -32'sd200 : $urandom;
      tick();
    end
    in_valid = 1'b0;
    repeat (70) tick();

    // Long back-pressure in HOLD.
    in_valid = 1'b1;
    in_data1 = $urandom;
    in_data2 = $urandom;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (40) tick();
    out_ready = 1'b1;
    repeat (6) tick();

    // Directed flag cases: zero sum, positive overflow.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data1 = (i == 0) ? 32'd5 : 32'h7FFFFFFF;
      in_data2 = (i == 0) ? -32'sd5 : 32'd1;
      tick();
    end
    in_valid = 1'b0;
    repeat (25) tick();

    // Forced core outputs.
    force_mode = 1;
    in_valid = 1'b1;
    in_data1 = $urandom;
    in_data2 = $urandom;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    force_mode = 0;

    // Random traffic with random back-pressure.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data1  = $urandom;
      in_data2  = $urandom;
      out_ready = ($urandom_range(0, 1) != 0);
      tick();
    end

    // Drain, then reset in the middle of WAIT with two pairs queued.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (60) tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data1 = $urandom;
      in_data2 = $urandom;
      tick();
    end
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_inflight && (m_k == m_pop_edge + 3) && (m_q.size() >= 2)) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t6_reach_wait", 64'(found), 64'(1));
    #2 resetn = 1'b0;
    #1 chk_reset("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_reset("rst_hold");
    @(negedge clk) resetn = 1'b1;
    model_reset();
    repeat (40) tick();

    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 1) != 0);
      in_data1  = $urandom;
      in_data2  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
